// File: rtl/led_panel_rx.sv
// led_panel_rx: receives a HUB75-style LED panel bus and re-emits each latched
// row as a ready/valid pixel stream, column 0 first.
//
// Ports
//   clk, rst            system clock, asynchronous active-high reset
//   RGB0, RGB1          top/bottom half pixel data (panel clock domain)
//   ADDR                row address (panel clock domain)
//   BLANK, LATCH, SCLK  panel blank, latch and shift clock (panel clock domain)
//   px_valid, px_ready  pixel-stream handshake
//   px_x, px_row        column and row of the current pixel
//   px_rgb0, px_rgb1    top and bottom pixel colour
//   px_last             current pixel is the last of the row
//   px_frame_start      row being streamed has address 0
//   overrun, row_err    sticky error flags, cleared only by reset
module led_panel_rx #(
    parameter int unsigned WIDTH       = 64,
    parameter int unsigned ADDR_BITS   = 5,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               RGB0,
    input  logic [2:0]               RGB1,
    input  logic [ADDR_BITS-1:0]     ADDR,
    input  logic                     BLANK,
    input  logic                     LATCH,
    input  logic                     SCLK,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [$clog2(WIDTH)-1:0] px_x,
    output logic [ADDR_BITS-1:0]     px_row,
    output logic [2:0]               px_rgb0,
    output logic [2:0]               px_rgb1,
    output logic                     px_last,
    output logic                     px_frame_start,
    output logic                     overrun,
    output logic                     row_err
);

    localparam int unsigned XW   = $clog2(WIDTH);
    localparam int unsigned CW   = $clog2(WIDTH + 2);
    localparam int unsigned IN_W = ADDR_BITS + 9;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                 state, state_nxt;
    logic [IN_W-1:0]        sync_q [SYNC_STAGES];
    logic [2:0]             rgb0_s, rgb1_s;
    logic [ADDR_BITS-1:0]   addr_s;
    logic                   blank_s, latch_s, sclk_s;
    logic                   sclk_d, latch_d;
    logic                   sclk_rise, latch_rise;
    logic [CW-1:0]          col_cnt, cnt_nxt;
    logic [5:0]             shift_buf [WIDTH];
    logic [5:0]             shift_nxt [WIDTH];
    logic [5:0]             out_buf   [WIDTH];
    logic                   accept, drop, advance;
    logic [XW-1:0]          x_inc;

    // Synchronizer chain shared by all panel inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {ADDR, BLANK, LATCH, SCLK, RGB1, RGB0};
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {addr_s, blank_s, latch_s, sclk_s, rgb1_s, rgb0_s} = sync_q[SYNC_STAGES-1];

    // Edge detectors on the synchronized strobes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_d  <= 1'b0;
            latch_d <= 1'b0;
        end else begin
            sclk_d  <= sclk_s;
            latch_d <= latch_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_d;
    assign latch_rise = latch_s & ~latch_d;
    assign x_inc      = px_x + XW'(1);

    // Newest pixel enters at x=0; the value seen by a same-cycle latch includes it
    always_comb begin
        shift_nxt = shift_buf;
        if (sclk_rise) begin
            shift_nxt[0] = {rgb1_s, rgb0_s};
            for (int i = 1; i < int'(WIDTH); i++) shift_nxt[i] = shift_buf[i-1];
        end
    end

    // Saturating shift count, including a shift coincident with the latch
    always_comb begin
        cnt_nxt = col_cnt;
        if (sclk_rise && col_cnt != CW'(WIDTH + 1)) cnt_nxt = col_cnt + CW'(1);
    end

    // Pixel storage carries no reset
    always_ff @(posedge clk) begin
        shift_buf <= shift_nxt;
        if (accept) out_buf <= shift_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             col_cnt <= '0;
        else if (latch_rise) col_cnt <= '0;
        else                 col_cnt <= cnt_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle control strobes
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        drop      = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (latch_rise) begin
                    accept    = 1'b1;
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                drop = latch_rise;
                if (px_valid && px_ready) begin
                    advance = 1'b1;
                    if (px_x == XW'(WIDTH - 1)) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered pixel-stream outputs and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_valid       <= 1'b0;
            px_x           <= '0;
            px_row         <= '0;
            px_rgb0        <= '0;
            px_rgb1        <= '0;
            px_last        <= 1'b0;
            px_frame_start <= 1'b0;
            overrun        <= 1'b0;
            row_err        <= 1'b0;
        end else begin
            if (accept) begin
                px_valid       <= 1'b1;
                px_x           <= '0;
                px_row         <= addr_s;
                px_rgb0        <= shift_nxt[0][2:0];
                px_rgb1        <= shift_nxt[0][5:3];
                px_last        <= 1'b0;
                px_frame_start <= (addr_s == '0);
                if (cnt_nxt != CW'(WIDTH) || !blank_s) row_err <= 1'b1;
            end else if (advance) begin
                if (state_nxt == IDLE) begin
                    px_valid       <= 1'b0;
                    px_x           <= '0;
                    px_last        <= 1'b0;
                    px_frame_start <= 1'b0;
                end else begin
                    px_x    <= x_inc;
                    px_rgb0 <= out_buf[x_inc][2:0];
                    px_rgb1 <= out_buf[x_inc][5:3];
                    px_last <= (x_inc == XW'(WIDTH - 1));
                end
            end
            if (drop) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_led_panel_rx.sv
// tb_led_panel_rx: directed stimulus for led_panel_rx, checked against a
// pixel-history model of the panel bus (what was shifted, what was latched).
module tb_led_panel_rx;

    localparam int W  = 64;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    RGB0 = '0, RGB1 = '0;
    logic [AB-1:0] ADDR = '0;
    logic          BLANK = 1'b1, LATCH = 1'b0, SCLK = 1'b0;
    logic          px_valid, px_ready;
    logic [5:0]    px_x;
    logic [AB-1:0] px_row;
    logic [2:0]    px_rgb0, px_rgb1;
    logic          px_last, px_frame_start, overrun, row_err;

    led_panel_rx #(.WIDTH(W), .ADDR_BITS(AB), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .RGB0(RGB0), .RGB1(RGB1), .ADDR(ADDR),
        .BLANK(BLANK), .LATCH(LATCH), .SCLK(SCLK),
        .px_valid(px_valid), .px_ready(px_ready),
        .px_x(px_x), .px_row(px_row),
        .px_rgb0(px_rgb0), .px_rgb1(px_rgb1),
        .px_last(px_last), .px_frame_start(px_frame_start),
        .overrun(overrun), .row_err(row_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    // Model: every pixel ever shifted, and the row captured at each accepted latch
    int hist[$];
    int m_cnt = 0, m_beat = 0, m_row = 0, beats = 0;
    bit m_stream = 0, m_rerr = 0, m_ovr = 0;
    int exp_px [W];
    bit exp_known [W];
    int got_rgb0 [W], got_rgb1 [W];
    int ready_mode = 0;

    function automatic int pat(input int sel, input int i);
        case (sel)
            0:       return (i % 8) | ((i % 8) << 3);
            1:       return (i % 8) | (((i / 8) % 8) << 3);
            default: return ((i * 3 + 1) % 8) | (((i * 5 + 2) % 8) << 3);
        endcase
    endfunction

    task automatic m_shift(input int pix);
        hist.push_back(pix);
        if (m_cnt < W + 1) m_cnt++;
    endtask

    task automatic m_latch(input int addr, input bit blank);
        if (m_stream) m_ovr = 1;
        else begin
            for (int x = 0; x < W; x++) begin
                int idx;
                idx = hist.size() - 1 - x;
                exp_known[x] = (idx >= 0);
                exp_px[x]    = (idx >= 0) ? hist[idx] : 0;
            end
            if (m_cnt != W || !blank) m_rerr = 1;
            m_row    = addr;
            m_beat   = 0;
            beats    = 0;
            m_stream = 1;
        end
        m_cnt = 0;
    endtask

    // Ready generator: 0 = always ready, 1 = toggle every cycle, 2 = stalled
    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       px_ready = 1'b1;
                1:       px_ready = ~px_ready;
                default: px_ready = 1'b0;
            endcase
        end
    end

    // Compare every presented beat with the modelled row
    always @(negedge clk) begin
        if (rst === 1'b0 && px_valid === 1'b1) begin
            if (!m_stream) chk("spurious_valid", 1, 0);
            else begin
                chk("px_x", int'(px_x), m_beat);
                if (exp_known[m_beat]) begin
                    chk("px_rgb0", int'(px_rgb0), exp_px[m_beat] & 7);
                    chk("px_rgb1", int'(px_rgb1), exp_px[m_beat] >> 3);
                end
                chk("px_last", int'(px_last), int'(m_beat == W - 1));
                chk("px_frame_start", int'(px_frame_start), int'(m_row == 0));
                chk("px_row", int'(px_row), m_row);
                if (px_ready) begin
                    got_rgb0[m_beat] = int'(px_rgb0);
                    got_rgb1[m_beat] = int'(px_rgb1);
                    beats++;
                    m_beat++;
                    if (m_beat == W) m_stream = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic shift_px(input int pix);
        RGB0 = 3'(pix & 7);
        RGB1 = 3'(pix >> 3);
        step(); step();
        SCLK = 1'b1;
        m_shift(pix);
        step(); step();
        SCLK = 1'b0;
    endtask

    task automatic shift_row(input int n, input int sel);
        for (int i = 0; i < n; i++) shift_px(pat(sel, i));
    endtask

    // sim_pix >= 0 puts an SCLK rise in the same cycle as the LATCH rise
    task automatic latch_row(input int addr, input bit blank, input int sim_pix, input bit lat_chk);
        ADDR  = AB'(addr);
        BLANK = blank;
        if (sim_pix >= 0) begin
            RGB0 = 3'(sim_pix & 7);
            RGB1 = 3'(sim_pix >> 3);
        end
        step(); step();
        LATCH = 1'b1;
        if (sim_pix >= 0) begin
            SCLK = 1'b1;
            m_shift(sim_pix);
        end
        m_latch(addr, blank);
        step(); step();
        if (lat_chk) chk("latency_early", int'(px_valid), 0);
        step();
        if (lat_chk) begin
            chk("latency_valid", int'(px_valid), 1);
            chk("latency_x", int'(px_x), 0);
        end
        LATCH = 1'b0;
        SCLK  = 1'b0;
        step(); step();
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 3000 && m_stream; i++) step();
        if (m_stream) begin
            chk({name, "_timeout"}, 0, 1);
            m_stream = 0;
        end
        step(); step();
    endtask

    task automatic chk_flags(input string name);
        chk({name, "_row_err"}, int'(row_err), int'(m_rerr));
        chk({name, "_overrun"}, int'(overrun), int'(m_ovr));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        m_stream = 0; m_cnt = 0; m_rerr = 0; m_ovr = 0;
        step(); step(); step();
        rst = 1'b0;
        step(); step();
    endtask

    initial begin
        // Reset values
        step(); step(); step();
        chk("rst_valid", int'(px_valid), 0);
        chk("rst_x", int'(px_x), 0);
        chk("rst_row", int'(px_row), 0);
        chk("rst_last", int'(px_last), 0);
        chk("rst_frame", int'(px_frame_start), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_row_err", int'(row_err), 0);
        rst = 1'b0;
        step();

        // Full row, ADDR=3, always ready
        shift_row(64, 0);
        latch_row(3, 1'b1, -1, 1'b1);
        wait_idle("t1");
        chk("t1_beats", beats, 64);
        chk("t1_rgb0_x0", got_rgb0[0], 7);
        chk("t1_rgb0_x10", got_rgb0[10], 5);
        chk("t1_rgb0_x63", got_rgb0[63], 0);
        chk("t1_rgb1_x0", got_rgb1[0], 7);
        chk("t1_row_err", int'(row_err), 0);
        chk_flags("t1");

        // Same shape with px_ready toggling
        ready_mode = 1;
        shift_row(64, 1);
        latch_row(4, 1'b1, -1, 1'b0);
        wait_idle("t2");
        ready_mode = 0;
        chk("t2_beats", beats, 64);
        chk("t2_rgb1_x0", got_rgb1[0], 7);
        chk("t2_rgb1_x20", got_rgb1[20], 5);
        chk("t2_rgb0_x20", got_rgb0[20], 3);
        chk("t2_rgb1_x63", got_rgb1[63], 0);
        chk_flags("t2");

        // 64th shift coincides with the latch
        shift_row(63, 2);
        latch_row(7, 1'b1, pat(2, 63), 1'b0);
        wait_idle("t3");
        chk("t3_beats", beats, 64);
        chk("t3_rgb0_x0", got_rgb0[0], 6);
        chk("t3_rgb1_x0", got_rgb1[0], 5);
        chk("t3_row_err", int'(row_err), 0);
        chk_flags("t3");

        // Short row: error flagged, row still streams
        shift_row(63, 0);
        latch_row(8, 1'b1, -1, 1'b0);
        wait_idle("t4");
        chk("t4_beats", beats, 64);
        chk("t4_row_err", int'(row_err), 1);
        chk_flags("t4");

        // Long row: first pixel discarded
        do_reset();
        chk("t5_row_err_cleared", int'(row_err), 0);
        shift_row(65, 0);
        latch_row(2, 1'b1, -1, 1'b0);
        wait_idle("t5");
        chk("t5_row_err", int'(row_err), 1);
        chk("t5_rgb0_x63", got_rgb0[63], 1);
        chk("t5_rgb0_x62", got_rgb0[62], 2);
        chk("t5_rgb0_x0", got_rgb0[0], 0);
        chk_flags("t5");

        // BLANK low at latch
        do_reset();
        shift_row(64, 1);
        latch_row(9, 1'b0, -1, 1'b0);
        wait_idle("t5b");
        chk("t5b_row_err", int'(row_err), 1);
        chk_flags("t5b");

        // Second latch while stalled: overrun, original row intact
        do_reset();
        ready_mode = 2;
        shift_row(64, 1);
        latch_row(5, 1'b1, -1, 1'b0);
        shift_row(64, 2);
        latch_row(6, 1'b1, -1, 1'b0);
        chk("t6_overrun", int'(overrun), 1);
        chk("t6_stalled_valid", int'(px_valid), 1);
        ready_mode = 0;
        wait_idle("t6");
        chk("t6_beats", beats, 64);
        chk("t6_rgb1_x0", got_rgb1[0], 7);
        chk("t6_rgb0_x63", got_rgb0[63], 0);
        chk_flags("t6");

        // ADDR=0 row, reset in the middle of the stream
        do_reset();
        shift_row(64, 0);
        latch_row(0, 1'b1, -1, 1'b0);
        for (int i = 0; i < 200 && m_beat < 20; i++) step();
        chk("t7_reached_beat20", int'(m_beat >= 20), 1);
        rst = 1'b1;
        m_stream = 0;
        #1;
        chk("t7_valid_in_reset", int'(px_valid), 0);
        chk("t7_frame_in_reset", int'(px_frame_start), 0);
        step(); step(); step();
        rst = 1'b0;
        m_cnt = 0; m_rerr = 0; m_ovr = 0;
        for (int i = 0; i < 20; i++) step();
        chk("t7_valid_after_reset", int'(px_valid), 0);

        // Recovery with a fresh row
        shift_row(64, 2);
        latch_row(1, 1'b1, -1, 1'b1);
        wait_idle("t8");
        chk("t8_beats", beats, 64);
        chk_flags("t8");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
